// File: rtl/kbd_pkg.sv
// Shared types and helpers for the PS/2 scan-code-set-2 key decoder.
// Prefix/modifier byte values, FSM state, event record and ASCII mapping.
package kbd_pkg;

    localparam int KBD_CNT_MAX_W = 16;

    localparam logic [7:0] PFX_EXT    = 8'hE0;
    localparam logic [7:0] PFX_BRK    = 8'hF0;
    localparam logic [7:0] MOD_LSHIFT = 8'h12;
    localparam logic [7:0] MOD_RSHIFT = 8'h59;
    localparam logic [7:0] MOD_CAPS   = 8'h58;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } kbd_state_t;

    // count is sized for the widest supported counter; narrower builds zero-extend
    typedef struct packed {
        logic [7:0]               ascii;
        logic [7:0]               scan;
        logic                     ext;
        logic [KBD_CNT_MAX_W-1:0] count;
    } kbd_event_t;

    function automatic logic [7:0] scan2ascii(input logic [7:0] code,
                                              input logic       ext,
                                              input logic       upper);
        logic [7:0] a;
        a = 8'h00;
        if (ext) begin
            case (code)
                8'h5A:   a = 8'h0D;
                8'h4A:   a = 8'h2F;
                default: a = 8'h00;
            endcase
        end else begin
            case (code)
                8'h1C: a = 8'h61;  8'h32: a = 8'h62;  8'h21: a = 8'h63;
                8'h23: a = 8'h64;  8'h24: a = 8'h65;  8'h2B: a = 8'h66;
                8'h34: a = 8'h67;  8'h33: a = 8'h68;  8'h43: a = 8'h69;
                8'h3B: a = 8'h6A;  8'h42: a = 8'h6B;  8'h4B: a = 8'h6C;
                8'h3A: a = 8'h6D;  8'h31: a = 8'h6E;  8'h44: a = 8'h6F;
                8'h4D: a = 8'h70;  8'h15: a = 8'h71;  8'h2D: a = 8'h72;
                8'h1B: a = 8'h73;  8'h2C: a = 8'h74;  8'h3C: a = 8'h75;
                8'h2A: a = 8'h76;  8'h1D: a = 8'h77;  8'h22: a = 8'h78;
                8'h35: a = 8'h79;  8'h1A: a = 8'h7A;
                8'h45: a = 8'h30;  8'h16: a = 8'h31;  8'h1E: a = 8'h32;
                8'h26: a = 8'h33;  8'h25: a = 8'h34;  8'h2E: a = 8'h35;
                8'h36: a = 8'h36;  8'h3D: a = 8'h37;  8'h3E: a = 8'h38;
                8'h46: a = 8'h39;
                8'h29: a = 8'h20;  8'h5A: a = 8'h0D;  8'h66: a = 8'h08;
                8'h0D: a = 8'h09;  8'h76: a = 8'h1B;
                default: a = 8'h00;
            endcase
        end
        if (upper && (a >= 8'h61) && (a <= 8'h7A))
            a = a - 8'h20;
        return a;
    endfunction

endpackage

// File: rtl/kbd_event_fifo.sv
// Synchronous FIFO of key events; a push into a full FIFO succeeds only when a
// pop happens on the same edge, otherwise it is dropped and flagged on o_drop.
module kbd_event_fifo
    import kbd_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_push,
    input  kbd_event_t i_data,
    input  logic       i_pop,
    output kbd_event_t o_data,
    output logic       o_full,
    output logic       o_empty,
    output logic       o_drop
);
    localparam int AW = $clog2(DEPTH);

    kbd_event_t    r_mem [DEPTH];
    logic [AW:0]   r_wr;
    logic [AW:0]   r_rd;
    logic          w_do_pop;
    logic          w_do_push;

    assign o_empty   = (r_wr == r_rd);
    assign o_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_drop    = i_push && o_full && !w_do_pop;
    assign o_data    = o_empty ? '0 : r_mem[r_rd[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + 1'b1;
            if (w_do_pop)  r_rd <= r_rd + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 byte stream to key-press events, buffered in an event FIFO.
// Define KBD_SHIFT_EN to enable shift/caps-lock tracking and uppercase letters.
module ps2_key_decoder
    import kbd_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_ascii,
    output logic [7:0]       out_scan,
    output logic             out_ext,
    output logic [CNT_W-1:0] out_count,
    output logic             caps_lock,
    output logic             key_held,
    output logic             overflow
);
    kbd_state_t       r_state;
    kbd_state_t       w_state_nxt;
    logic             w_make;
    logic             w_brk;
    logic             w_ext;
    logic             w_is_mod;
    logic             w_upper;
    logic             w_hit;
    logic             w_new_key;
    logic             r_held_vld;
    logic [7:0]       r_held_code;
    logic             r_held_ext;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_push_p0;
    kbd_event_t       r_evt_p0;
    kbd_event_t       w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_drop;
    logic [KBD_CNT_MAX_W-1:0] w_unused_cnt;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_make      = 1'b0;
        w_brk       = 1'b0;
        w_ext       = 1'b0;
        if (in_valid) begin
            case (r_state)
                ST_IDLE: begin
                    if (in_data == PFX_EXT)      w_state_nxt = ST_EXT;
                    else if (in_data == PFX_BRK) w_state_nxt = ST_BRK;
                    else                         w_make = 1'b1;
                end
                ST_EXT: begin
                    if (in_data == PFX_BRK)      w_state_nxt = ST_EXT_BRK;
                    else if (in_data == PFX_EXT) w_state_nxt = ST_EXT;
                    else begin
                        w_make      = 1'b1;
                        w_ext       = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    w_brk       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_brk       = 1'b1;
                    w_ext       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

`ifdef KBD_SHIFT_EN
    logic r_shift;
    logic r_caps;
    logic r_caps_held;

    assign w_is_mod  = (in_data == MOD_LSHIFT) || (in_data == MOD_RSHIFT) || (in_data == MOD_CAPS);
    assign w_upper   = r_shift ^ r_caps;
    assign caps_lock = r_caps;

    // caps toggles once per physical press; typematic repeats are held off by r_caps_held
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift     <= 1'b0;
            r_caps      <= 1'b0;
            r_caps_held <= 1'b0;
        end else if (w_is_mod) begin
            if (in_data == MOD_CAPS) begin
                if (w_make) begin
                    r_caps_held <= 1'b1;
                    if (!r_caps_held) r_caps <= ~r_caps;
                end else if (w_brk) begin
                    r_caps_held <= 1'b0;
                end
            end else begin
                if (w_make)     r_shift <= 1'b1;
                else if (w_brk) r_shift <= 1'b0;
            end
        end
    end
`else
    assign w_is_mod  = 1'b0;
    assign w_upper   = 1'b0;
    assign caps_lock = 1'b0;
`endif

    assign w_hit     = r_held_vld && (r_held_ext == w_ext) && (r_held_code == in_data);
    assign w_new_key = w_make && !w_is_mod && !w_hit;
    assign w_cnt_nxt = r_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_held_vld <= 1'b0;
            r_cnt      <= '0;
            r_push_p0  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (w_new_key)                         r_held_vld <= 1'b1;
            else if (w_brk && !w_is_mod && w_hit)  r_held_vld <= 1'b0;
            if (w_new_key) r_cnt <= w_cnt_nxt;
            r_push_p0 <= w_new_key;
            if (w_drop) overflow <= 1'b1;
        end
    end

    // decode stage -> FIFO write stage
    always_ff @(posedge clk) begin
        if (w_new_key) begin
            r_held_code    <= in_data;
            r_held_ext     <= w_ext;
            r_evt_p0.ascii <= scan2ascii(in_data, w_ext, w_upper);
            r_evt_p0.scan  <= in_data;
            r_evt_p0.ext   <= w_ext;
            r_evt_p0.count <= KBD_CNT_MAX_W'(w_cnt_nxt);
        end
    end

    kbd_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_push_p0),
        .i_data  (r_evt_p0),
        .i_pop   (out_ready),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_drop  (w_drop)
    );

    assign w_unused_cnt = w_head.count;
    assign out_valid    = !w_empty;
    assign out_ascii    = w_head.ascii;
    assign out_scan     = w_head.scan;
    assign out_ext      = w_head.ext;
    assign out_count    = w_head.count[CNT_W-1:0];
    assign key_held     = r_held_vld;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: expected events are queued as bytes are
// driven and compared as the DUT hands them out. Honours KBD_SHIFT_EN.
module tb_ps2_key_decoder;
    localparam int DEPTH = 8;
    localparam int CW    = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [7:0]    out_ascii;
    logic [7:0]    out_scan;
    logic          out_ext;
    logic [CW-1:0] out_count;
    logic          caps_lock;
    logic          key_held;
    logic          overflow;

    typedef struct {
        logic [7:0] ascii;
        logic [7:0] scan;
        logic       ext;
        logic [7:0] count;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   exp_cnt = 0;

    always #5 clk = ~clk;

    ps2_key_decoder #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ascii (out_ascii),
        .out_scan  (out_scan),
        .out_ext   (out_ext),
        .out_count (out_count),
        .caps_lock (caps_lock),
        .key_held  (key_held),
        .overflow  (overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // called at a negedge; leaves in_valid low at the following negedge
    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_make(input logic [7:0] code, input logic ext,
                             input logic [7:0] ascii, input logic keep);
        exp_t e;
        exp_cnt++;
        e.ascii = ascii;
        e.scan  = code;
        e.ext   = ext;
        e.count = 8'(exp_cnt);
        if (keep) q.push_back(e);
        if (ext) send(8'hE0);
        send(code);
    endtask

    task automatic send_break(input logic [7:0] code, input logic ext);
        if (ext) send(8'hE0);
        send(8'hF0);
        send(code);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        exp_cnt = 0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
        check("sb_drained", q.size(), 0);
        @(negedge clk);
        @(negedge clk);
        check("empty_after_drain", out_valid, 1'b0);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("unexpected_event", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("ev_ascii", out_ascii, e.ascii);
                check("ev_scan",  out_scan,  e.scan);
                check("ev_ext",   out_ext,   e.ext);
                check("ev_count", out_count, e.count);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [7:0] ov_code  [9];
    logic [7:0] ov_ascii [9];

    initial begin
        ov_code  = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};
        ov_ascii = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h69};

        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_ascii", out_ascii, 0);
        check("rst_out_scan",  out_scan,  0);
        check("rst_out_ext",   out_ext,   0);
        check("rst_out_count", out_count, 0);
        check("rst_caps",      caps_lock, 0);
        check("rst_key_held",  key_held,  0);
        check("rst_overflow",  overflow,  0);
        rst = 1'b0;
        @(negedge clk);

        // single press with latency check
        send_make(8'h1C, 1'b0, 8'h61, 1'b1);
        check("lat_edge_n", out_valid, 0);
        check("held_after_make", key_held, 1);
        @(negedge clk);
        check("lat_edge_n1", out_valid, 1);
        send_break(8'h1C, 1'b0);
        check("held_after_break", key_held, 0);
        drain();

        // typematic repeats
        send_make(8'h1C, 1'b0, 8'h61, 1'b1);
        send(8'h1C);
        send(8'h1C);
        send_break(8'h1C, 1'b0);
        drain();

`ifdef KBD_SHIFT_EN
        send(8'h12);
        send_make(8'h1C, 1'b0, 8'h41, 1'b1);
        send_break(8'h1C, 1'b0);
        send_break(8'h12, 1'b0);
        send(8'h58);
        send(8'h58);
        send_break(8'h58, 1'b0);
        check("caps_on", caps_lock, 1);
        send_make(8'h1C, 1'b0, 8'h41, 1'b1);
        send_break(8'h1C, 1'b0);
        send(8'h12);
        send_make(8'h1C, 1'b0, 8'h61, 1'b1);
        send_break(8'h1C, 1'b0);
        send_break(8'h12, 1'b0);
        send(8'h58);
        send_break(8'h58, 1'b0);
        check("caps_off", caps_lock, 0);
        send_make(8'h1C, 1'b0, 8'h61, 1'b1);
        send_break(8'h1C, 1'b0);
`else
        send_make(8'h12, 1'b0, 8'h00, 1'b1);
        send_break(8'h12, 1'b0);
        send_make(8'h58, 1'b0, 8'h00, 1'b1);
        send_break(8'h58, 1'b0);
        check("caps_tied", caps_lock, 0);
        send_make(8'h1C, 1'b0, 8'h61, 1'b1);
        send_break(8'h1C, 1'b0);
`endif
        drain();

        // digits and control keys, back to back
        send_make(8'h45, 1'b0, 8'h30, 1'b1);
        send_make(8'h46, 1'b0, 8'h39, 1'b1);
        send_make(8'h29, 1'b0, 8'h20, 1'b1);
        send_make(8'h5A, 1'b0, 8'h0D, 1'b1);
        send_make(8'h66, 1'b0, 8'h08, 1'b1);
        send_make(8'h76, 1'b0, 8'h1B, 1'b1);
        send_break(8'h76, 1'b0);
        drain();

        // extended keys
        send_make(8'h5A, 1'b1, 8'h0D, 1'b1);
        send_break(8'h5A, 1'b1);
        send_make(8'h75, 1'b1, 8'h00, 1'b1);
        send_break(8'h75, 1'b1);
        send_make(8'h4A, 1'b1, 8'h2F, 1'b1);
        send_make(8'h4A, 1'b0, 8'h00, 1'b1);
        send_break(8'h4A, 1'b0);
        drain();

        // overflow with consumer stalled
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++)
            send_make(ov_code[i], 1'b0, ov_ascii[i], i < DEPTH);
        @(negedge clk);
        @(negedge clk);
        check("ovf_set",      overflow,  1);
        check("ovf_valid",    out_valid, 1);
        check("stall_count",  out_count, 1);
        repeat (3) @(negedge clk);
        check("stall_ascii",  out_ascii, 8'h61);
        check("stall_count2", out_count, 1);
        out_ready = 1'b1;
        drain();
        check("ovf_sticky", overflow, 1);

        // reset in the middle of an E0 sequence
        send(8'hE0);
        do_reset();
        check("ovf_cleared", overflow, 0);
        send_make(8'h1C, 1'b0, 8'h61, 1'b1);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Sequential PS/2 scan-code-set-2 decoder between the PS/2 byte receiver and the display/console logic. It consumes raw received bytes and tracks E0/F0 prefix sequences, held-key and modifier state. It converts each new key press into an event carrying ASCII, scan code and a running press count, buffered in a parametrised FIFO with a valid/ready output handshake.

## Interface
- FIFO_DEPTH, 8, event FIFO entries; power of two, ≥2
- CNT_W, 8, width of the key-press counter
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  one-cycle strobe, in_data holds a complete received byte
- in_data  input  8  received PS/2 byte
- out_valid  output  1  FIFO head holds an event
- out_ready  input  1  consumer accepts head when out_valid & out_ready
- out_ascii  output  8  ASCII of head event, 0x00 if unmapped
- out_scan  output  8  scan code of head event, prefix bytes stripped
- out_ext  output  1  head event was E0-prefixed
- out_count  output  CNT_W  press count at the time of the head event
- caps_lock  output  1  current caps-lock toggle state
- key_held  output  1  a non-modifier key is currently held
- overflow  output  1  sticky: an event was dropped on a full FIFO

## Operation
- Prefix FSM states: IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0). Advances only on in_valid.
- IDLE: E0→EXT, F0→BRK, other byte→make(ext=0), stay IDLE. EXT: F0→EXT_BRK, E0→EXT, other→make(ext=1), →IDLE. BRK→break(ext=0), →IDLE. EXT_BRK→break(ext=1), →IDLE.
- Modifiers: 0x12/0x59 set shift on make and clear it on break. 0x58 make toggles caps_lock when caps is not already held. Modifiers never push events and never update the held key.
- Make of a non-modifier: if {ext,code} equals the held key, it is a typematic repeat and is ignored. Otherwise record it as the held key, increment the counter (wraps at 2^CNT_W), and push {ascii, code, ext, new count}.
- Break of a non-modifier: clear the held key if it matches. No event.
- ASCII map (non-ext):
  - letters 1C,32,21,23,24,2B,34,33,43,3B,42,4B,3A,31,44,4D,15,2D,1B,2C,3C,2A,1D,22,35,1A map to a–z
  - digits 45,16,1E,26,25,2E,36,3D,3E,46 map to 0–9
  - 29→0x20, 5A→0x0D, 66→0x08, 0D→0x09, 76→0x1B
- ASCII map (ext): E0 5A→0x0D, E0 4A→0x2F. All other ext codes and unmapped codes → 0x00, but the event is still pushed.
- Letter case: uppercase when shift XOR caps_lock.
- FIFO full, pop low: push dropped, overflow=1 until rst.
- FIFO full, pop same cycle: pop and push both occur, no drop.
- Empty FIFO: out_* data fields hold 0x00/0.

## Timing
- Reset values: out_valid=0, out_ascii=0, out_scan=0, out_ext=0, out_count=0, caps_lock=0, key_held=0, overflow=0. FSM=IDLE, shift=0, counter=0, FIFO empty.
- Latency: in_valid of the final make byte at edge N → out_valid=1 after edge N+1, provided the FIFO was empty.
- Back-to-back in_valid on every cycle is supported; no input stall exists.
- out_* are stable while out_valid & !out_ready.
- rst mid-sequence (e.g. after E0): prefix discarded, FIFO flushed, modifiers and held key cleared, all on the same edge.

## Configuration
- KBD_SHIFT_EN defined: shift/caps tracking and uppercase mapping as above; caps_lock output live.
- KBD_SHIFT_EN undefined: no modifier state, letters always lowercase, caps_lock tied 0. Codes 12/59/58 are treated as ordinary unmapped keys: they push events with ascii 0x00.

## Structure
- Package kbd_pkg holds:
  - the FSM state enum
  - constants for prefix codes (8'hE0, 8'hF0) and modifier codes
  - the kbd_event_t struct {ascii, scan, ext, count}
  - function scan2ascii(code, ext, upper)
- Sub-module kbd_event_fifo: synchronous FIFO of kbd_event_t, FIFO_DEPTH deep, with full/empty and same-cycle push/pop.

## Test plan
- Input 1C, F0 1C with out_ready=1 → exactly one event: ascii 0x61, scan 0x1C, ext 0, count 1; key_held returns to 0.
- Input 1C ×3 then F0 1C → a single event only (typematic repeats suppressed).
- Input 12, 1C, F0 1C, F0 12 → ascii 0x41. Then 58, F0 58, 1C → caps_lock=1, ascii 0x41. Then 12, 1C → ascii 0x61 (shift XOR caps).
- Input E0 5A, E0 F0 5A → ascii 0x0D, scan 0x5A, ext 1. Input E0 75 → ascii 0x00, ext 1, event still pushed.
- out_ready=0, FIFO_DEPTH+1 distinct makes → FIFO full, overflow=1. Draining yields counts 1..FIFO_DEPTH in order.
- Input E0, rst pulse, then 1C → decoded as a non-ext 'a' with count 1, and overflow=0.
